// File: rtl/dwn_sampler_avg_pkg.sv
// Shared constants and sizing helpers for the decimator and its neighbours.
package dwn_smp_pkg;

   localparam logic MODE_PICK = 1'b0;
   localparam logic MODE_AVG  = 1'b1;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   // Room for the sum of 2^max_log2 samples plus the rounding term.
   function automatic int unsigned acc_w(input int unsigned dw, input int unsigned max_log2);
      return dw + max_log2 + 1;
   endfunction

endpackage

// File: rtl/dwn_sampler_avg_rst_sync2.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second clk edge.
module rst_sync2 (
   input  logic clk,
   input  logic rst_n,
   output logic rst_sync_n
);

   logic m_rst_n_q, m_rst_n_d;
   logic d_rst_n_q, d_rst_n_d;

   // Shift a one through the chain once reset is released.
   always_comb begin
      m_rst_n_d = 1'b1;
      d_rst_n_d = m_rst_n_q;
   end

   // Synchroniser flops, cleared directly by the raw reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rst_n_q <= 1'b0;
         d_rst_n_q <= 1'b0;
      end else begin
         m_rst_n_q <= m_rst_n_d;
         d_rst_n_q <= d_rst_n_d;
      end
   end

   assign rst_sync_n = d_rst_n_q;

endmodule

// File: rtl/dwn_sampler_avg.sv
// Decimator: one output per 2^L accepted samples, either the last sample or the rounded mean.
module dwn_sampler_avg
   import dwn_smp_pkg::*;
#(
   parameter int unsigned DW       = 32,
   parameter int unsigned MAX_LOG2 = 4
) (
   input  logic                              sys_clk,
   input  logic                              sys_rst_n,
   input  logic                              sys_ce,
   output logic                              sys_async_rst_n,
   input  logic [DW-1:0]                     sys_audio_sample,
   input  logic                              sys_smp_vld,
   input  logic                              sys_flush,
   input  logic                              cfg_mode,
   input  logic [clog2(MAX_LOG2+1)-1:0]      cfg_dec_log2,
   output logic [DW-1:0]                     dwn_smp_audio_sample,
   output logic                              dwn_smp_smp_vld,
   output logic                              dwn_smp_busy
);

   localparam int unsigned ACC_W = acc_w(DW, MAX_LOG2);
   localparam int unsigned LW    = clog2(MAX_LOG2 + 1);
   localparam int unsigned CW    = MAX_LOG2;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             act_mode_q, act_mode_d;
   logic [LW-1:0]    act_l_q, act_l_d;
   logic [DW-1:0]    out_q, out_d;
   logic             vld_q, vld_d;
   logic             busy_q, busy_d;

   logic                    grp_start;
   logic                    eff_mode;
   logic [LW-1:0]           cfg_l_c;
   logic [LW-1:0]           eff_l;
   logic [CW:0]             n_full;
   logic [CW-1:0]           last_cnt;
   logic [ACC_W-1:0]        sext;
   logic [ACC_W-1:0]        sum;
   logic [ACC_W-1:0]        rnd;
   logic signed [ACC_W-1:0] rsum;
   logic signed [ACC_W-1:0] avg_full;

   // Synchronised reset; also clears every flop below.
   rst_sync2 u_rst_sync2 (
      .clk        (sys_clk),
      .rst_n      (sys_rst_n),
      .rst_sync_n (sys_async_rst_n)
   );

   // Group counting, accumulation, config latch and output selection.
   always_comb begin
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      act_mode_d = act_mode_q;
      act_l_d    = act_l_q;
      out_d      = out_q;
      vld_d      = 1'b0;

      cfg_l_c   = (cfg_dec_log2 > LW'(MAX_LOG2)) ? LW'(MAX_LOG2) : cfg_dec_log2;
      grp_start = (cnt_q == '0);
      // At a group start the live config applies, so L = 0 passes through immediately.
      eff_mode  = grp_start ? cfg_mode : act_mode_q;
      eff_l     = grp_start ? cfg_l_c  : act_l_q;

      n_full   = (CW+1)'(1) << eff_l;
      last_cnt = CW'(n_full - (CW+1)'(1));

      sext     = {{(ACC_W-DW){sys_audio_sample[DW-1]}}, sys_audio_sample};
      sum      = grp_start ? sext : acc_q + sext;
      rnd      = (eff_l == '0) ? '0 : (ACC_W'(1) << (eff_l - LW'(1)));
      rsum     = sum + rnd;
      avg_full = rsum >>> eff_l;

      if (sys_ce) begin
         if (grp_start) begin
            act_mode_d = cfg_mode;
            act_l_d    = cfg_l_c;
         end
         if (sys_flush) begin
            cnt_d = '0;
            acc_d = '0;
         end else if (sys_smp_vld) begin
            acc_d = sum;
            if (cnt_q == last_cnt) begin
               cnt_d = '0;
               vld_d = 1'b1;
               out_d = (eff_mode == MODE_AVG) ? DW'(avg_full) : sys_audio_sample;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end

      busy_d = (cnt_d != '0);
   end

   // Counter, accumulator and active config.
   always_ff @(posedge sys_clk or negedge sys_async_rst_n) begin
      if (!sys_async_rst_n) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         act_mode_q <= 1'b0;
         act_l_q    <= '0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         act_mode_q <= act_mode_d;
         act_l_q    <= act_l_d;
      end
   end

   // Output register.
   always_ff @(posedge sys_clk or negedge sys_async_rst_n) begin
      if (!sys_async_rst_n) begin
         out_q  <= '0;
         vld_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         vld_q  <= vld_d;
         busy_q <= busy_d;
      end
   end

   assign dwn_smp_audio_sample = out_q;
   assign dwn_smp_smp_vld      = vld_q;
   assign dwn_smp_busy         = busy_q;

endmodule
